// File: rtl/circuito_exp_5.sv
// Progressive memory game: control FSM plus datapath (round/address counters, ROM,
// play register, comparators, button edge detector) with debug and 7-segment outputs.
module circuito_exp_5 (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  output logic [3:0] leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_jogadaIgualMemoria,
  output logic       db_enderecoIgualSequencia,
  output logic       db_tem_jogada,
  output logic [3:0] db_sequencia,
  output logic [3:0] db_endereco,
  output logic [3:0] db_memoria,
  output logic [3:0] db_estado,
  output logic [3:0] db_jogada,
  output logic [6:0] display_sequencia,
  output logic [6:0] display_jogada,
  output logic [6:0] display_memoria,
  output logic [6:0] display_endereco,
  output logic [6:0] display_estado,
  output logic       db_fimS
);

  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARACAO  = 4'h1;
  localparam logic [3:0] INICIO_SEQ  = 4'h2;
  localparam logic [3:0] ESPERA      = 4'h3;
  localparam logic [3:0] REGISTRA    = 4'h4;
  localparam logic [3:0] COMPARACAO  = 4'h5;
  localparam logic [3:0] PROXIMO     = 4'h6;
  localparam logic [3:0] PROX_SEQ    = 4'h7;
  localparam logic [3:0] FIM_GANHOU  = 4'hA;
  localparam logic [3:0] FIM_PERDEU  = 4'hE;

  logic [3:0] r_estado;
  logic [3:0] r_sequencia;
  logic [3:0] r_endereco;
  logic [3:0] r_jogada;
  logic       r_tem_jogada_d;

  logic [3:0] w_prox_estado;
  logic [3:0] w_memoria;
  logic       w_tem_jogada;
  logic       w_pulse;
  logic       w_igual;
  logic       w_end_eq_seq;
  logic       w_fim_s;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Sequence ROM, read asynchronously at the current address
  always_comb begin
    case (r_endereco)
      4'h0: w_memoria = 4'h1;
      4'h1: w_memoria = 4'h2;
      4'h2: w_memoria = 4'h4;
      4'h3: w_memoria = 4'h8;
      4'h4: w_memoria = 4'h4;
      4'h5: w_memoria = 4'h2;
      4'h6: w_memoria = 4'h1;
      4'h7: w_memoria = 4'h1;
      4'h8: w_memoria = 4'h2;
      4'h9: w_memoria = 4'h2;
      4'hA: w_memoria = 4'h4;
      4'hB: w_memoria = 4'h4;
      4'hC: w_memoria = 4'h8;
      4'hD: w_memoria = 4'h8;
      4'hE: w_memoria = 4'h1;
      default: w_memoria = 4'h4;
    endcase
  end

  assign w_tem_jogada = |botoes;
  assign w_pulse      = w_tem_jogada & ~r_tem_jogada_d;
  assign w_igual      = (r_jogada == w_memoria);
  assign w_end_eq_seq = (r_endereco == r_sequencia);
  assign w_fim_s      = (r_sequencia == 4'hF);

  always_comb begin
    w_prox_estado = INICIAL;
    case (r_estado)
      INICIAL:     w_prox_estado = jogar ? PREPARACAO : INICIAL;
      PREPARACAO:  w_prox_estado = INICIO_SEQ;
      INICIO_SEQ:  w_prox_estado = ESPERA;
      ESPERA:      w_prox_estado = w_pulse ? REGISTRA : ESPERA;
      REGISTRA:    w_prox_estado = COMPARACAO;
      COMPARACAO: begin
        if (!w_igual)           w_prox_estado = FIM_PERDEU;
        else if (!w_end_eq_seq) w_prox_estado = PROXIMO;
        else if (!w_fim_s)      w_prox_estado = PROX_SEQ;
        else                    w_prox_estado = FIM_GANHOU;
      end
      PROXIMO:     w_prox_estado = ESPERA;
      PROX_SEQ:    w_prox_estado = INICIO_SEQ;
      FIM_GANHOU:  w_prox_estado = jogar ? PREPARACAO : FIM_GANHOU;
      FIM_PERDEU:  w_prox_estado = jogar ? PREPARACAO : FIM_PERDEU;
      default:     w_prox_estado = INICIAL;
    endcase
  end

  // Datapath control is decoded from the current state, so each action lands on the
  // edge that leaves that state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado       <= INICIAL;
      r_sequencia    <= '0;
      r_endereco     <= '0;
      r_jogada       <= '0;
      r_tem_jogada_d <= 1'b0;
    end else begin
      r_estado       <= w_prox_estado;
      r_tem_jogada_d <= w_tem_jogada;
      case (r_estado)
        PREPARACAO: begin
          r_sequencia <= '0;
          r_endereco  <= '0;
          r_jogada    <= '0;
        end
        INICIO_SEQ: r_endereco  <= '0;
        REGISTRA:   r_jogada    <= botoes;
        PROXIMO:    r_endereco  <= r_endereco + 4'd1;
        PROX_SEQ:   r_sequencia <= r_sequencia + 4'd1;
        default: ;
      endcase
    end
  end

  assign ganhou = (r_estado == FIM_GANHOU);
  assign perdeu = (r_estado == FIM_PERDEU);
  assign pronto = ganhou | perdeu;

  assign leds                      = r_jogada;
  assign db_jogadaIgualMemoria     = w_igual;
  assign db_enderecoIgualSequencia = w_end_eq_seq;
  assign db_tem_jogada             = w_tem_jogada;
  assign db_sequencia              = r_sequencia;
  assign db_endereco               = r_endereco;
  assign db_memoria                = w_memoria;
  assign db_estado                 = r_estado;
  assign db_jogada                 = r_jogada;
  assign db_fimS                   = w_fim_s;

  assign display_sequencia = hex7(r_sequencia);
  assign display_jogada    = hex7(r_jogada);
  assign display_memoria   = hex7(w_memoria);
  assign display_endereco  = hex7(r_endereco);
  assign display_estado    = hex7(r_estado);

endmodule

// File: tb/tb_circuito_exp_5.sv
// Directed self-checking bench for circuito_exp_5: reset, start, single round, loss,
// full win, restart and ignored presses.
module tb_circuito_exp_5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic [3:0] botoes = 4'h0;
  logic [3:0] leds;
  logic       pronto, ganhou, perdeu;
  logic       db_jogadaIgualMemoria, db_enderecoIgualSequencia, db_tem_jogada;
  logic [3:0] db_sequencia, db_endereco, db_memoria, db_estado, db_jogada;
  logic [6:0] display_sequencia, display_jogada, display_memoria, display_endereco, display_estado;
  logic       db_fimS;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [3:0] rom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  circuito_exp_5 dut (
    .clock                     (clock),
    .reset                     (reset),
    .jogar                     (jogar),
    .botoes                    (botoes),
    .leds                      (leds),
    .pronto                    (pronto),
    .ganhou                    (ganhou),
    .perdeu                    (perdeu),
    .db_jogadaIgualMemoria     (db_jogadaIgualMemoria),
    .db_enderecoIgualSequencia (db_enderecoIgualSequencia),
    .db_tem_jogada             (db_tem_jogada),
    .db_sequencia              (db_sequencia),
    .db_endereco               (db_endereco),
    .db_memoria                (db_memoria),
    .db_estado                 (db_estado),
    .db_jogada                 (db_jogada),
    .display_sequencia         (display_sequencia),
    .display_jogada            (display_jogada),
    .display_memoria           (display_memoria),
    .display_endereco          (display_endereco),
    .display_estado            (display_estado),
    .db_fimS                   (db_fimS)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Hold a button pattern long enough to be registered, then release and let the
  // FSM return to the wait state.
  task automatic press(input logic [3:0] b);
    botoes = b;
    tick(4);
    botoes = 4'h0;
    tick(3);
  endtask

  initial begin
    // Reset and idle
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    check("rst_estado", 8'(db_estado), 8'h0);
    check("rst_pronto", 8'(pronto), 8'h0);
    check("rst_ganhou", 8'(ganhou), 8'h0);
    check("rst_perdeu", 8'(perdeu), 8'h0);
    check("rst_disp_estado", 8'(display_estado), 8'h40);
    check("rst_memoria", 8'(db_memoria), 8'h1);
    check("rst_disp_mem", 8'(display_memoria), 8'h79);

    // Start: 0 -> 1 -> 2 -> 3, jogar held while in 3 is ignored
    jogar = 1'b1;
    tick(1);
    check("start_s1", 8'(db_estado), 8'h1);
    tick(1);
    check("start_s2", 8'(db_estado), 8'h2);
    tick(1);
    check("start_s3", 8'(db_estado), 8'h3);
    tick(2);
    jogar = 1'b0;
    tick(2);
    check("idle_s3", 8'(db_estado), 8'h3);
    check("idle_seq", 8'(db_sequencia), 8'h0);
    check("idle_end", 8'(db_endereco), 8'h0);
    check("idle_eqseq", 8'(db_enderecoIgualSequencia), 8'h1);

    // Round 0: held button for 10 cycles yields a single pulse
    botoes = 4'h1;
    tick(1);
    check("tem_jogada", 8'(db_tem_jogada), 8'h1);
    tick(9);
    botoes = 4'h0;
    tick(2);
    check("r0_seq", 8'(db_sequencia), 8'h1);
    check("r0_estado", 8'(db_estado), 8'h3);
    check("r0_leds", 8'(leds), 8'h1);
    check("r0_end", 8'(db_endereco), 8'h0);
    check("r0_eqseq", 8'(db_enderecoIgualSequencia), 8'h0);

    // Rounds 1 and 2 correct, round 3 fails on the second play
    press(4'h1); press(4'h2);
    check("r1_seq", 8'(db_sequencia), 8'h2);
    press(4'h1); press(4'h2); press(4'h4);
    check("r2_seq", 8'(db_sequencia), 8'h3);
    press(4'h1);
    check("r3_end", 8'(db_endereco), 8'h1);
    press(4'hA);
    check("lose_perdeu", 8'(perdeu), 8'h1);
    check("lose_pronto", 8'(pronto), 8'h1);
    check("lose_ganhou", 8'(ganhou), 8'h0);
    check("lose_estado", 8'(db_estado), 8'hE);
    check("lose_seq", 8'(db_sequencia), 8'h3);
    check("lose_end", 8'(db_endereco), 8'h1);
    check("lose_igual", 8'(db_jogadaIgualMemoria), 8'h0);
    check("lose_jogada", 8'(db_jogada), 8'hA);
    check("lose_disp_estado", 8'(display_estado), 8'h06);

    // Restart from loss
    jogar = 1'b1;
    tick(1);
    jogar = 1'b0;
    check("restart_s1", 8'(db_estado), 8'h1);
    check("restart_pronto", 8'(pronto), 8'h0);
    check("restart_perdeu", 8'(perdeu), 8'h0);
    tick(1);
    check("restart_seq", 8'(db_sequencia), 8'h0);
    check("restart_end", 8'(db_endereco), 8'h0);
    check("restart_leds", 8'(leds), 8'h0);
    tick(1);
    check("restart_s3", 8'(db_estado), 8'h3);

    // Full winning game
    for (int unsigned r = 0; r < 16; r++) begin
      if (r == 14) check("fimS_r14", 8'(db_fimS), 8'h0);
      if (r == 15) begin
        check("fimS_r15", 8'(db_fimS), 8'h1);
        check("disp_seq_F", 8'(display_sequencia), 8'h0E);
      end
      for (int unsigned a = 0; a <= r; a++) press(rom[a]);
    end
    check("win_ganhou", 8'(ganhou), 8'h1);
    check("win_pronto", 8'(pronto), 8'h1);
    check("win_perdeu", 8'(perdeu), 8'h0);
    check("win_estado", 8'(db_estado), 8'hA);
    check("win_end", 8'(db_endereco), 8'hF);
    check("win_leds", 8'(leds), 8'h4);

    // Restart from win
    jogar = 1'b1;
    tick(1);
    jogar = 1'b0;
    check("rewin_s1", 8'(db_estado), 8'h1);
    check("rewin_ganhou", 8'(ganhou), 8'h0);
    tick(2);
    check("rewin_seq", 8'(db_sequencia), 8'h0);
    check("rewin_s3", 8'(db_estado), 8'h3);

    // Mid-game reset while a press is pending, then a press in state 0 is ignored
    botoes = 4'h2;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    botoes = 4'h0;
    tick(2);
    check("midrst_estado", 8'(db_estado), 8'h0);
    check("midrst_jogada", 8'(db_jogada), 8'h0);
    press(4'h4);
    check("s0_ignore_estado", 8'(db_estado), 8'h0);
    check("s0_ignore_leds", 8'(leds), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
